truth_table_probe: RTL and testbench
====================================

TRUTH_TABLE_PROBE -- requirements
Module: truth_table_probe

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles each input vector is held before its response is sampled; legal range 2..255.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flops in the sense-input synchronizer; SETTLE_CYCLES < SYNC_STAGES SHALL fail elaboration.
REQ-003 SHALL have parameter PASSES, default 2: full sweeps per measurement; legal range 1..4.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one measurement; sampled only in IDLE.
REQ-007 sense  input  1  output of the 3-input logic block under test; asynchronous to clk.
REQ-008 in1, in2, in3  output  1 each  registered stimulus driven to the block under test; in1 is the MSB.
REQ-009 busy  output  1  high while a measurement is in progress.
REQ-010 done  output  1  one-cycle pulse when a measurement completes.
REQ-011 code  output  8  measured truth-table code.
REQ-012 valid  output  1  code holds a completed measurement.
REQ-013 stable  output  1  all passes of the last measurement produced identical codes.

Function
REQ-014 SHALL be the inverse of a truth-table gate: sweep {in1,in2,in3} over all 8 vectors and reconstruct the 8-bit code.
REQ-015 Bit mapping SHALL be MSB-first: code[7-i] = synchronized sense sampled while {in1,in2,in3} = i.
REQ-016 States SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE: outputs in1..in3 = 000; busy = 0. When start = 1, go to SETTLE with idx = 0 and pass = 0; clear valid and stable; drive vector 0.
REQ-018 SETTLE: hold the vector for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SAMPLE (one cycle): write the synchronized sense into shadow bit 7-idx.
REQ-020 SAMPLE with idx < 7: increment idx, drive the new vector, return to SETTLE.
REQ-021 SAMPLE with idx = 7 on pass 0: store the shadow as the first-pass code.
REQ-022 SAMPLE with idx = 7 on later passes: compare the shadow with the first-pass code and set the sticky mismatch flag on any difference.
REQ-023 SAMPLE with idx = 7 when pass < PASSES-1: increment pass, set idx = 0, go to SETTLE; otherwise go to DONE.
REQ-024 DONE (one cycle): code = first-pass code; valid = 1; stable = !mismatch; done = 1; in1..in3 = 000. Then go to IDLE.
REQ-025 busy SHALL be 1 in SETTLE, SAMPLE and DONE.
REQ-026 Latency: start sampled at edge T SHALL give done high in cycle T + 1 + PASSES*8*(SETTLE_CYCLES+1); defaults give T+81.
REQ-027 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-028 start held high continuously SHALL begin a new measurement on the cycle after each DONE.
REQ-029 code, valid and stable SHALL hold their values until the next accepted start or reset.
REQ-030 Counters SHALL be sized for their maxima: idx 3 bits, pass 2 bits, settle counter 8 bits; no wrap-around within a measurement.

Reset
REQ-031 reset SHALL take priority over every other input, including start.
REQ-032 After reset: state IDLE; in1..in3 = 000; busy = 0; done = 0; code = 8'h00; valid = 0; stable = 0; synchronizer flops = 0.
REQ-033 reset during a measurement SHALL abort it; no done pulse is produced and stale shadow data is not kept.

Structure
REQ-034 Package truth_table_probe_pkg SHALL hold the state enum, NUM_VECTORS = 8 and CODE_W = 8.
REQ-035 The synchronizer SHALL be the sub-module sense_sync (parameter STAGES, reset value 0).
REQ-036 The block SHALL contain only the FSM, counters and shadow registers.

Verification
REQ-037 Behavioral model of rule 0xB5 as sense (000→1, 001→0, 010→1, 011→1, 100→0, 101→1, 110→0, 111→1), start pulse -> done at T+81, code = 8'hB5, valid = 1, stable = 1.
REQ-038 Constant-0 and constant-1 models -> code = 8'h00 and 8'hFF, stable = 1.
REQ-039 Model whose 011 response flips between passes -> code = first-pass value, stable = 0.
REQ-040 reset asserted at cycle T+40 of a measurement -> no done pulse, code = 8'h00, valid = 0, in1..in3 = 000 on the next cycle.
REQ-041 start pulsed again at T+10 -> ignored, single done at T+81; start held high -> consecutive measurements with done every 81 cycles.
REQ-042 SETTLE_CYCLES = 2 with a model that has 1-cycle output delay -> correct code; the vector sequence seen on in1..in3 is 0..7 per pass.

Source files
------------

// File: rtl/truth_table_probe_pkg.sv
// truth_table_probe_pkg
//    Shared definitions for the truth-table probe: FSM state encoding,
//    sweep geometry and a helper that places one sampled response bit into
//    the MSB-first code word.
package truth_table_probe_pkg;

   localparam int NUM_VECTORS = 8;
   localparam int CODE_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Vector i lands in code bit 7-i, so vector 000 ends up as the MSB.
   function automatic logic [CODE_W-1:0] put_msb_first(
      input logic [CODE_W-1:0] word,
      input logic [2:0]        idx,
      input logic              bit_val
   );
      logic [CODE_W-1:0] r;
      r = word;
      r[3'(CODE_W-1) - idx] = bit_val;
      return r;
   endfunction

endpackage

// File: rtl/truth_table_probe_sense_sync.sv
// sense_sync
//    Multi-flop synchronizer that brings the asynchronous sense line into
//    the clk domain. All stages clear to 0 on reset.
//
//    clk   : rising-edge clock
//    reset : synchronous, active-high reset
//    d     : asynchronous input
//    q     : synchronized output (last stage)
module sense_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stage_q;
   logic [STAGES-1:0] stage_d;

   assign stage_d[0] = d;

   genvar gi;
   generate
      for (gi = 1; gi < STAGES; gi++) begin : g_stage
         assign stage_d[gi] = stage_q[gi-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/truth_table_probe.sv
// truth_table_probe
//    Reverse-engineers a 3-input combinational block: drives all eight input
//    vectors onto in1..in3, waits SETTLE_CYCLES per vector, samples the
//    synchronized response and rebuilds the 8-bit truth-table code. The
//    sweep is repeated PASSES times; any disagreement with the first pass
//    clears 'stable'.
//
//    clk        : rising-edge clock
//    reset      : synchronous, active-high reset (highest priority)
//    start      : measurement request, honoured when not mid-measurement
//    sense      : response of the block under test (asynchronous)
//    in1..in3   : registered stimulus, in1 is the MSB of the vector
//    busy       : measurement in progress (SETTLE, SAMPLE, DONE)
//    done       : one-cycle completion pulse
//    code       : first-pass truth-table code, MSB-first
//    valid      : code holds a completed measurement
//    stable     : all passes agreed with the first pass
module truth_table_probe
   import truth_table_probe_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int PASSES        = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              sense,
   output logic              in1,
   output logic              in2,
   output logic              in3,
   output logic              busy,
   output logic              done,
   output logic [CODE_W-1:0] code,
   output logic              valid,
   output logic              stable
);

   // Parameter legality is checked at elaboration.
   generate
      if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
         $error("truth_table_probe: SETTLE_CYCLES must be 2..255");
      end
      if (SETTLE_CYCLES < SYNC_STAGES || SYNC_STAGES < 1) begin : g_bad_sync
         $error("truth_table_probe: SYNC_STAGES must be 1..SETTLE_CYCLES");
      end
      if (PASSES < 1 || PASSES > 4) begin : g_bad_passes
         $error("truth_table_probe: PASSES must be 1..4");
      end
   endgenerate

   logic sense_s;

   sense_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sense_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sense),
      .q     (sense_s)
   );

   state_t            state_q,    state_d;
   logic [2:0]        idx_q,      idx_d;
   logic [1:0]        pass_q,     pass_d;
   logic [7:0]        settle_q,   settle_d;
   logic [CODE_W-1:0] shadow_q,   shadow_d;
   logic [CODE_W-1:0] first_q,    first_d;
   logic              mismatch_q, mismatch_d;
   logic [CODE_W-1:0] code_q,     code_d;
   logic              valid_q,    valid_d;
   logic              stable_q,   stable_d;
   logic [2:0]        vec_q,      vec_d;

   logic [CODE_W-1:0] shadow_next;
   logic              pass_mis;
   logic              accept;

   // A start in DONE is accepted directly so that a held start produces
   // back-to-back measurements without an idle gap.
   assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pass_d      = pass_q;
      settle_d    = settle_q;
      shadow_d    = shadow_q;
      first_d     = first_q;
      mismatch_d  = mismatch_q;
      code_d      = code_q;
      valid_d     = valid_q;
      stable_d    = stable_q;
      vec_d       = vec_q;
      shadow_next = put_msb_first(shadow_q, idx_q, sense_s);
      pass_mis    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end

         ST_SETTLE: begin
            if (settle_q == 8'(SETTLE_CYCLES - 1)) begin
               state_d = ST_SAMPLE;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end

         ST_SAMPLE: begin
            shadow_d = shadow_next;
            if (idx_q != 3'(NUM_VECTORS - 1)) begin
               idx_d    = idx_q + 3'd1;
               vec_d    = idx_q + 3'd1;
               settle_d = 8'd0;
               state_d  = ST_SETTLE;
            end else begin
               // End of a sweep: pass 0 defines the reference code, later
               // passes only contribute to the sticky mismatch flag.
               pass_mis   = (pass_q != 2'd0) && (shadow_next != first_q);
               mismatch_d = mismatch_q | pass_mis;
               if (pass_q == 2'd0) begin
                  first_d = shadow_next;
               end
               if (pass_q < 2'(PASSES - 1)) begin
                  pass_d   = pass_q + 2'd1;
                  idx_d    = 3'd0;
                  vec_d    = 3'd0;
                  settle_d = 8'd0;
                  state_d  = ST_SETTLE;
               end else begin
                  // Results are registered on the way into DONE so they are
                  // visible in the same cycle as the done pulse.
                  state_d  = ST_DONE;
                  code_d   = (pass_q == 2'd0) ? shadow_next : first_q;
                  valid_d  = 1'b1;
                  stable_d = !(mismatch_q | pass_mis);
                  vec_d    = 3'd0;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         state_d    = ST_SETTLE;
         idx_d      = 3'd0;
         pass_d     = 2'd0;
         settle_d   = 8'd0;
         vec_d      = 3'd0;
         shadow_d   = '0;
         first_d    = '0;
         mismatch_d = 1'b0;
         valid_d    = 1'b0;
         stable_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= 3'd0;
         pass_q     <= 2'd0;
         settle_q   <= 8'd0;
         shadow_q   <= '0;
         first_q    <= '0;
         mismatch_q <= 1'b0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         stable_q   <= 1'b0;
         vec_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pass_q     <= pass_d;
         settle_q   <= settle_d;
         shadow_q   <= shadow_d;
         first_q    <= first_d;
         mismatch_q <= mismatch_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         stable_q   <= stable_d;
         vec_q      <= vec_d;
      end
   end

   assign in1    = vec_q[2];
   assign in2    = vec_q[1];
   assign in3    = vec_q[0];
   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign code   = code_q;
   assign valid  = valid_q;
   assign stable = stable_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// tb_truth_table_probe
//    Directed bench for truth_table_probe. Instance A uses default
//    parameters with a zero-delay behavioural block under test; instance B
//    uses SETTLE_CYCLES=2, SYNC_STAGES=1, PASSES=1 with a block whose output
//    lags its inputs by one clock.
//    Cycle numbering: cycle T+k is the clock period that ends at edge T+k,
//    so a done seen just after edge e is "done in cycle e+1".
module tb_truth_table_probe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset   = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic       sense_a;
   logic       sense_b = 1'b0;

   logic       in1_a, in2_a, in3_a, busy_a, done_a, valid_a, stable_a;
   logic [7:0] code_a;
   logic       in1_b, in2_b, in3_b, busy_b, done_b, valid_b, stable_b;
   logic [7:0] code_b;

   int n_checks = 0;
   int n_bad    = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   truth_table_probe u_dut_a (
      .clk    (clk),
      .reset  (reset),
      .start  (start_a),
      .sense  (sense_a),
      .in1    (in1_a),
      .in2    (in2_a),
      .in3    (in3_a),
      .busy   (busy_a),
      .done   (done_a),
      .code   (code_a),
      .valid  (valid_a),
      .stable (stable_a)
   );

   truth_table_probe #(
      .SETTLE_CYCLES (2),
      .SYNC_STAGES   (1),
      .PASSES        (1)
   ) u_dut_b (
      .clk    (clk),
      .reset  (reset),
      .start  (start_b),
      .sense  (sense_b),
      .in1    (in1_b),
      .in2    (in2_b),
      .in3    (in3_b),
      .busy   (busy_b),
      .done   (done_b),
      .code   (code_b),
      .valid  (valid_b),
      .stable (stable_b)
   );

   // Model A: combinational rule lookup; with flip_en the 011 response is
   // inverted from the second visit of vector 3 onward (i.e. pass 1).
   logic [7:0] rule_a  = 8'h00;
   logic       flip_en = 1'b0;
   int         visit3  = 0;
   logic [2:0] vec_a, vec_b, prev_vec_a;
   logic [7:0] rule_b  = 8'h00;

   assign vec_a = {in1_a, in2_a, in3_a};
   assign vec_b = {in1_b, in2_b, in3_b};

   always_comb begin
      sense_a = rule_a[~vec_a] ^ (flip_en && visit3 >= 2 && vec_a == 3'd3);
   end

   always @(posedge clk) begin
      prev_vec_a <= vec_a;
      if (!busy_a) visit3 <= 0;
      else if (vec_a == 3'd3 && prev_vec_a != 3'd3) visit3 <= visit3 + 1;
   end

   // Model B: same lookup but registered, one clock of output delay.
   always @(posedge clk) sense_b <= rule_b[~vec_b];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic kick_a(input logic hold, output int t);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      t = cyc;
      if (!hold) start_a = 1'b0;
   endtask

   // Returns the edge after which done_a was seen high, or -1 on timeout.
   task automatic wait_done_a(output int e);
      e = -1;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk);
         #1;
         if (done_a) begin
            e = cyc;
            break;
         end
      end
   endtask

   task automatic count_done_a(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         #1;
         if (done_a) n++;
      end
   endtask

   task automatic measure_a(input string tag, input logic [7:0] rule, input logic flip,
                            input logic [7:0] exp_code, input logic exp_stable);
      int t, e, lat;
      rule_a  = rule;
      flip_en = flip;
      kick_a(1'b0, t);
      chk({tag, "_busy"}, 32'(busy_a), 32'd1);
      wait_done_a(e);
      lat = (e < 0) ? 0 : e + 1 - t;
      chk({tag, "_latency"}, 32'(lat), 32'd81);
      chk({tag, "_code"}, 32'(code_a), 32'(exp_code));
      chk({tag, "_valid"}, 32'(valid_a), 32'd1);
      chk({tag, "_stable"}, 32'(stable_a), 32'(exp_stable));
      chk({tag, "_vec_done"}, 32'(vec_a), 32'd0);
      $display("txn %s: code=%h stable=%0d latency=%0d", tag, code_a, stable_a, lat);
      @(posedge clk);
      #1;
      chk({tag, "_done_width"}, 32'(done_a), 32'd0);
      chk({tag, "_idle"}, 32'(busy_a), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk({tag, "_code_hold"}, 32'(code_a), 32'(exp_code));
      chk({tag, "_valid_hold"}, 32'(valid_a), 32'd1);
      flip_en = 1'b0;
   endtask

   initial begin
      int t, e, e2, n;

      // ---- reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vec", 32'(vec_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_code", 32'(code_a), 32'h00);
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_stable", 32'(stable_a), 32'd0);
      reset = 1'b0;
      $display("txn reset: outputs cleared");

      // ---- main function under several rules
      measure_a("rule_b5", 8'hB5, 1'b0, 8'hB5, 1'b1);
      measure_a("const0", 8'h00, 1'b0, 8'h00, 1'b1);
      measure_a("const1", 8'hFF, 1'b0, 8'hFF, 1'b1);
      measure_a("flip011", 8'hB5, 1'b1, 8'hB5, 1'b0);

      // ---- start while busy is ignored and not queued
      rule_a = 8'hB5;
      kick_a(1'b0, t);
      repeat (9) @(posedge clk);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      wait_done_a(e);
      chk("ign_latency", 32'((e < 0) ? 0 : e + 1 - t), 32'd81);
      count_done_a(120, n);
      chk("ign_no_second_done", 32'(n), 32'd0);
      $display("txn ignored_start: latency=%0d extra_done=%0d", (e < 0) ? 0 : e + 1 - t, n);

      // ---- start held high: back-to-back measurements every 81 cycles
      rule_a = 8'h3C;
      kick_a(1'b1, t);
      wait_done_a(e);
      chk("held_latency", 32'((e < 0) ? 0 : e + 1 - t), 32'd81);
      chk("held_code1", 32'(code_a), 32'h3C);
      wait_done_a(e2);
      start_a = 1'b0;
      chk("held_period", 32'((e < 0 || e2 < 0) ? 0 : e2 - e), 32'd81);
      chk("held_code2", 32'(code_a), 32'h3C);
      $display("txn held_start: period=%0d", (e < 0 || e2 < 0) ? 0 : e2 - e);
      repeat (3) @(posedge clk);
      #1;

      // ---- reset in the middle of a measurement
      rule_a = 8'hB5;
      kick_a(1'b0, t);
      repeat (39) @(posedge clk);
      #1;
      chk("abort_code_before", 32'(code_a), 32'h3C);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort_vec", 32'(vec_a), 32'd0);
      chk("abort_busy", 32'(busy_a), 32'd0);
      chk("abort_done", 32'(done_a), 32'd0);
      chk("abort_code", 32'(code_a), 32'h00);
      chk("abort_valid", 32'(valid_a), 32'd0);
      count_done_a(120, n);
      chk("abort_no_done", 32'(n), 32'd0);
      $display("txn reset_abort: code=%h valid=%0d", code_a, valid_a);

      // ---- short settle with a delayed block, vector order check
      rule_b = 8'h6A;
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      t = cyc;
      start_b = 1'b0;
      for (int k = 0; k < 24; k++) begin
         if (k % 3 == 0) chk("b_vec_first", 32'(vec_b), 32'(k / 3));
         if (k % 3 == 2) chk("b_vec_last", 32'(vec_b), 32'(k / 3));
         @(posedge clk);
         #1;
      end
      chk("b_done", 32'(done_b), 32'd1);
      chk("b_latency", 32'(cyc + 1 - t), 32'd25);
      chk("b_code", 32'(code_b), 32'h6A);
      chk("b_valid", 32'(valid_b), 32'd1);
      chk("b_stable", 32'(stable_b), 32'd1);
      chk("b_vec_done", 32'(vec_b), 32'd0);
      $display("txn short_settle: code=%h", code_b);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
